// File: rtl/nonmax_feature_collector.sv
// rtl/nonmax_feature_collector.sv - collects non-max-suppressed feature points into a record FIFO
// Tracks raw pixel position and queues offset-corrected {x, y, strength} records with per-frame stats.
module nonmax_feature_collector #(
  parameter int BW         = 8,
  parameter int IM_WIDTH   = 640,
  parameter int IM_HEIGHT  = 480,
  parameter int X_OFF      = 3,
  parameter int Y_OFF      = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_FEAT   = 256,
  localparam int XW = $clog2(IM_WIDTH),
  localparam int YW = $clog2(IM_HEIGHT),
  localparam int CW = $clog2(MAX_FEAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          sof,
  input  logic [BW-1:0] strength_in,
  input  logic          feature_flag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [BW-1:0] out_strength,
  output logic          frame_done,
  output logic [CW-1:0] frame_feat_count,
  output logic          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = XW + YW + BW;
  localparam logic [XW-1:0] X_LAST  = XW'(IM_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IM_HEIGHT - 1);
  localparam logic [XW-1:0] X_OFF_C = XW'(X_OFF);
  localparam logic [YW-1:0] Y_OFF_C = YW'(Y_OFF);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_FEAT);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_feat_count;
  logic          r_ovf;
  logic          r_frame_done;
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic [RW-1:0] r_mem [FIFO_DEPTH];

  logic          w_sof_beat;
  logic [XW-1:0] w_cur_x;
  logic [YW-1:0] w_cur_y;
  logic          w_last_x;
  logic          w_last_y;
  logic          w_frame_end;
  logic          w_cand;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_cnt_base;
  logic [CW-1:0] w_cnt_next;
  logic          w_push;
  logic          w_pop;
  logic [RW-1:0] w_rec;
  logic [RW-1:0] w_head;

  // r_x/r_y hold the position the next beat will land on; sof overrides it to the origin.
  assign w_sof_beat  = in_valid & sof;
  assign w_cur_x     = w_sof_beat ? '0 : r_x;
  assign w_cur_y     = w_sof_beat ? '0 : r_y;
  assign w_last_x    = (w_cur_x == X_LAST);
  assign w_last_y    = (w_cur_y == Y_LAST);
  assign w_frame_end = in_valid & w_last_x & w_last_y;

  assign w_cand = in_valid & feature_flag & (strength_in != '0) &
                  (w_cur_x >= X_OFF_C) & (w_cur_y >= Y_OFF_C);

  assign w_empty    = (r_wr == r_rd);
  assign w_full     = ((r_wr - r_rd) == DEPTH_C);
  assign w_cnt_base = w_sof_beat ? '0 : r_cnt;
  assign w_push     = w_cand & ~w_full & (w_cnt_base < MAX_C);
  assign w_pop      = ~w_empty & out_ready;
  assign w_cnt_next = w_cnt_base + CW'(w_push);
  assign w_rec      = {w_cur_x - X_OFF_C, w_cur_y - Y_OFF_C, strength_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_cnt        <= '0;
      r_feat_count <= '0;
      r_ovf        <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr         <= '0;
      r_rd         <= '0;
    end else begin
      if (in_valid) begin
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? '0 : w_cur_y + 1'b1;
        end else begin
          r_x <= w_cur_x + 1'b1;
          r_y <= w_cur_y;
        end
      end
      r_cnt        <= w_frame_end ? '0 : w_cnt_next;
      r_ovf        <= (w_sof_beat ? 1'b0 : r_ovf) | (w_cand & w_full);
      r_frame_done <= w_frame_end;
      if (w_frame_end) r_feat_count <= w_cnt_next;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_rec;
  end

  // Head fields are gated so they read zero whenever the FIFO is empty, including after reset.
  assign w_head           = r_mem[r_rd[AW-1:0]];
  assign out_valid        = ~w_empty;
  assign out_x            = out_valid ? w_head[RW-1 -: XW] : '0;
  assign out_y            = out_valid ? w_head[BW +: YW] : '0;
  assign out_strength     = out_valid ? w_head[BW-1:0] : '0;
  assign frame_done       = r_frame_done;
  assign frame_feat_count = r_feat_count;
  assign overflow         = r_ovf;

endmodule

// File: tb/tb_nonmax_feature_collector.sv
// tb/tb_nonmax_feature_collector.sv - directed self-checking bench for nonmax_feature_collector
// Small 16x8 frame, MAX_FEAT=18 so both the FIFO-full and cap paths are reachable.
module tb_nonmax_feature_collector;

  localparam int W = 16;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] strength_in = '0;
  logic       feature_flag = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_x;
  logic [2:0] out_y;
  logic [7:0] out_strength;
  logic       frame_done;
  logic [4:0] frame_feat_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail = 0;
  int fd_cnt = 0;

  nonmax_feature_collector #(
    .BW(8), .IM_WIDTH(W), .IM_HEIGHT(H), .X_OFF(3), .Y_OFF(3),
    .FIFO_DEPTH(16), .MAX_FEAT(18)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sof(sof),
    .strength_in(strength_in), .feature_flag(feature_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_strength(out_strength), .frame_done(frame_done),
    .frame_feat_count(frame_feat_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic s, input logic f, input logic [7:0] st);
    @(negedge clk);
    in_valid = 1'b1; sof = s; feature_flag = f; strength_in = st;
    @(posedge clk);
    #1;
    in_valid = 1'b0; sof = 1'b0; feature_flag = 1'b0; strength_in = '0;
    if (frame_done) fd_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) fd_cnt++;
    end
  endtask

  // Frame from sof with 20 candidates at raw x=3..12 on rows 3 and 4, strengths 1..20; ends after beat 76.
  task automatic twenty_cand_frame();
    beat(1'b1, 1'b0, 8'h00);
    run(50);
    for (int i = 0; i < 10; i++) beat(1'b0, 1'b1, 8'(i + 1));
    run(6);
    for (int i = 10; i < 20; i++) beat(1'b0, 1'b1, 8'(i + 1));
  endtask

  initial begin
    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_feat_count", frame_feat_count, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single candidate at raw (10,5), then a full frame with exactly one frame_done.
    out_ready = 1'b1;
    fd_cnt = 0;
    beat(1'b1, 1'b0, 8'h00);
    run(89);
    beat(1'b0, 1'b1, 8'h40);
    check("t1_valid", out_valid, 1);
    check("t1_x", out_x, 7);
    check("t1_y", out_y, 2);
    check("t1_strength", out_strength, 8'h40);
    run(36);
    check("t1_no_early_done", fd_cnt, 0);
    beat(1'b0, 1'b0, 8'h00);
    check("t1_frame_done", frame_done, 1);
    check("t1_fd_cnt", fd_cnt, 1);
    check("t1_feat_count", frame_feat_count, 1);
    idle(1);
    check("t1_done_pulse", frame_done, 0);
    check("t1_count_hold", frame_feat_count, 1);

    // Rejected beats: below offset, and zero strength.
    beat(1'b1, 1'b0, 8'h00);
    run(81);
    beat(1'b0, 1'b1, 8'h40);
    check("t2_low_x_valid", out_valid, 0);
    run(7);
    beat(1'b0, 1'b1, 8'h00);
    check("t2_zero_str_valid", out_valid, 0);
    run(36);
    beat(1'b0, 1'b0, 8'h00);
    check("t2_feat_count", frame_feat_count, 0);

    // Backpressure: 20 candidates, FIFO keeps the first 16.
    out_ready = 1'b0;
    twenty_cand_frame();
    run(50);
    beat(1'b0, 1'b0, 8'h00);
    check("t3_frame_done", frame_done, 1);
    check("t3_feat_count", frame_feat_count, 16);
    check("t3_overflow", overflow, 1);
    idle(2);
    check("t3_hold_x", out_x, 0);
    check("t3_hold_strength", out_strength, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_pop_valid", out_valid, 1);
      check("t3_pop_x", out_x, (i < 10) ? i : i - 10);
      check("t3_pop_y", out_y, (i < 10) ? 0 : 1);
      check("t3_pop_strength", out_strength, i + 1);
      idle(1);
    end
    check("t3_drained", out_valid, 0);

    // Per-frame cap: consumer keeps up, only 18 of 20 are accepted; sof clears overflow.
    beat(1'b1, 1'b0, 8'h00);
    check("t4_sof_clears_ovf", overflow, 0);
    run(50);
    for (int i = 0; i < 10; i++) beat(1'b0, 1'b1, 8'(i + 1));
    run(6);
    for (int i = 10; i < 20; i++) beat(1'b0, 1'b1, 8'(i + 1));
    run(50);
    beat(1'b0, 1'b0, 8'h00);
    check("t4_feat_count_cap", frame_feat_count, 18);
    check("t4_overflow", overflow, 0);
    idle(1);
    check("t4_empty", out_valid, 0);

    // Mid-frame sof at raw (5,3): counters restart, no frame_done, FIFO kept.
    out_ready = 1'b0;
    fd_cnt = 0;
    beat(1'b1, 1'b0, 8'h00);
    run(51);
    beat(1'b0, 1'b1, 8'h55);
    beat(1'b1, 1'b1, 8'h11);
    run(50);
    beat(1'b0, 1'b1, 8'h66);
    run(75);
    check("t5_no_done", fd_cnt, 0);
    beat(1'b0, 1'b0, 8'h00);
    check("t5_frame_done", frame_done, 1);
    check("t5_feat_count", frame_feat_count, 1);
    check("t5_head_x", out_x, 1);
    check("t5_head_y", out_y, 0);
    check("t5_head_strength", out_strength, 8'h55);

    // Fill and overflow, then reset mid-frame.
    twenty_cand_frame();
    check("t6_overflow_set", overflow, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_feat_count", frame_feat_count, 0);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_x", out_x, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(51);
    beat(1'b0, 1'b1, 8'h77);
    check("t6_post_valid", out_valid, 1);
    check("t6_post_x", out_x, 0);
    check("t6_post_y", out_y, 0);
    check("t6_post_strength", out_strength, 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
